uart_rx_cfg: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, parity mode and stop-bit count, with 3-sample majority voting at each bit centre, false-start rejection and break detection. Received frames are presented through a one-deep valid/ready output register with error sidebands. Sits between the rxd pad and a byte/word consumer (command decoder or FIFO).

---
 rtl/uart_rx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: majority-voted sampling, parity/stop checks,
// break detection and a one-deep valid/ready output register.
module uart_rx_cfg #(
   parameter int CLK_HZ    = 200_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int SYNC_LEN  = 2
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 break_det,
   output logic                 rx_busy
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV);

   localparam logic [CW-1:0] S0   = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] S1   = CW'(DIV / 2);
   localparam logic [CW-1:0] S2   = CW'(DIV / 2 + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic       ODD       = (PARITY == 2);

   if (DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 ||
       PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_LEN < 2)
   begin : g_param_chk
      $error("uart_rx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP, BRK_WAIT
   } state_t;

   state_t                state;
   logic [SYNC_LEN-1:0]   sync;
   logic                  prev;
   logic [CW-1:0]         cnt;
   logic [3:0]            idx;
   logic                  s0, s1;
   logic [DATA_BITS-1:0]  sh;
   logic                  xacc, perr, ferr, pbit;

   logic rxd_s, maj, dec, fe_next;

   assign rxd_s   = sync[SYNC_LEN-1];
   assign maj     = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
   assign dec     = (cnt == S2);
   assign fe_next = ferr | ~maj;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= IDLE;
         sync       <= '1;
         prev       <= 1'b1;
         cnt        <= '0;
         idx        <= '0;
         s0         <= 1'b1;
         s1         <= 1'b1;
         sh         <= '0;
         xacc       <= 1'b0;
         perr       <= 1'b0;
         ferr       <= 1'b0;
         pbit       <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
         rx_busy    <= 1'b0;
      end else begin
         sync      <= {sync[SYNC_LEN-2:0], rxd};
         prev      <= rxd_s;
         overrun   <= 1'b0;
         break_det <= 1'b0;

         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;

         if (state != IDLE)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
         if (cnt == S0)
            s0 <= rxd_s;
         if (cnt == S1)
            s1 <= rxd_s;

         // busy must already be low on the final decision cycle
         if (state == STOP && idx == LAST_STOP && cnt == S1)
            rx_busy <= 1'b0;

         unique case (state)
            IDLE: begin
               if (!rxd_s && prev) begin
                  state   <= START;
                  cnt     <= CW'(1);
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (dec) begin
                  if (maj) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state <= DATA;
                     idx   <= '0;
                     xacc  <= 1'b0;
                     perr  <= 1'b0;
                     ferr  <= 1'b0;
                     pbit  <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (dec) begin
                  sh   <= {maj, sh[DATA_BITS-1:1]};
                  xacc <= xacc ^ maj;
                  if (idx == LAST_DATA) begin
                     idx   <= '0;
                     state <= (PARITY != 0) ? PAR : STOP;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            PAR: begin
               if (dec) begin
                  perr  <= xacc ^ maj ^ ODD;
                  pbit  <= maj;
                  state <= STOP;
               end
            end
            STOP: begin
               if (dec) begin
                  if (idx == '0 && !maj && sh == '0 && !pbit) begin
                     break_det <= 1'b1;
                     rx_busy   <= 1'b0;
                     state     <= BRK_WAIT;
                  end else if (idx == LAST_STOP) begin
                     state <= IDLE;
                     if (!rx_valid || rx_ready) begin
                        rx_data    <= sh;
                        parity_err <= perr;
                        frame_err  <= fe_next;
                        rx_valid   <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     ferr <= fe_next;
                     idx  <= idx + 4'd1;
                  end
               end
            end
            BRK_WAIT: begin
               if (rxd_s)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7O1 and 8N2 instances at DIV=16,
// shared clock and reset, one rxd/rx_ready per instance.
module tb_uart_rx_cfg;

   localparam int DIV = 16;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
   logic rdy_a = 1'b1, rdy_b = 1'b0, rdy_c = 1'b0;

   logic [7:0] data_a, data_c;
   logic [6:0] data_b;
   logic valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;
   logic valid_b, perr_b, ferr_b, ovr_b, brk_b, busy_b;
   logic valid_c, perr_c, ferr_c, ovr_c, brk_c, busy_c;

   uart_rx_cfg #(.CLK_HZ(153_600), .BAUD(9600), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .SYNC_LEN(2)) u_a (
      .clk(clk), .nrst(nrst), .rxd(rxd_a), .rx_data(data_a),
      .rx_valid(valid_a), .rx_ready(rdy_a), .parity_err(perr_a),
      .frame_err(ferr_a), .overrun(ovr_a), .break_det(brk_a),
      .rx_busy(busy_a));

   uart_rx_cfg #(.CLK_HZ(153_600), .BAUD(9600), .DATA_BITS(7),
                 .PARITY(2), .STOP_BITS(1), .SYNC_LEN(2)) u_b (
      .clk(clk), .nrst(nrst), .rxd(rxd_b), .rx_data(data_b),
      .rx_valid(valid_b), .rx_ready(rdy_b), .parity_err(perr_b),
      .frame_err(ferr_b), .overrun(ovr_b), .break_det(brk_b),
      .rx_busy(busy_b));

   uart_rx_cfg #(.CLK_HZ(153_600), .BAUD(9600), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(2), .SYNC_LEN(2)) u_c (
      .clk(clk), .nrst(nrst), .rxd(rxd_c), .rx_data(data_c),
      .rx_valid(valid_c), .rx_ready(rdy_c), .parity_err(perr_c),
      .frame_err(ferr_c), .overrun(ovr_c), .break_det(brk_c),
      .rx_busy(busy_c));

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int t_valid = 0, t_bfall = 0;
   int v_rise = 0, b_rise = 0, ovr_cnt = 0, brk_cnt = 0;
   logic v_q = 1'b0, b_q = 1'b0;

   always @(posedge clk) cyc = cyc + 1;

   // event recorder for instance A, sampled mid-cycle
   always @(negedge clk) begin
      if (valid_a && !v_q) begin
         v_rise = v_rise + 1;
         t_valid = cyc;
      end
      if (busy_a && !b_q) b_rise = b_rise + 1;
      if (!busy_a && b_q) t_bfall = cyc;
      if (ovr_a) ovr_cnt = ovr_cnt + 1;
      if (brk_a) brk_cnt = brk_cnt + 1;
      v_q = valid_a;
      b_q = busy_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic line(input int sel, input logic v);
      case (sel)
         0: rxd_a = v;
         1: rxd_b = v;
         default: rxd_c = v;
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] frame(input logic [8:0] d, input int nd,
                                         input int has_par, input logic pb,
                                         input logic [1:0] stops, input int ns);
      logic [15:0] b;
      int pos;
      b = '0;
      for (int i = 0; i < nd; i++) b[1+i] = d[i];
      pos = 1 + nd;
      if (has_par != 0) begin
         b[pos] = pb;
         pos++;
      end
      for (int s = 0; s < ns; s++) b[pos+s] = stops[s];
      return b;
   endfunction

   // glitch_t / rdy_t are cycle offsets from the start bit, -1 = unused
   task automatic send(input int sel, input logic [15:0] bits, input int n,
                       input int glitch_t, input int rdy_t);
      for (int t = 0; t < n * DIV; t++) begin
         logic v;
         v = bits[t/DIV];
         if (t == glitch_t) v = ~v;
         if (rdy_t >= 0) rdy_a = (t == rdy_t);
         line(sel, v);
         tick(1);
      end
      line(sel, 1'b1);
   endtask

   int t0, b0, v0, br0, ov0, b1;

   initial begin
      tick(3);
      chk("rst_valid", valid_a, 0);
      chk("rst_data", data_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_flags", {perr_a, ferr_a, ovr_a, brk_a}, 0);
      nrst = 1'b1;
      tick(5);

      t0 = cyc;
      send(0, frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1), 10, -1, -1);
      chk("8n1_latency", t_valid - t0, 156);
      chk("8n1_busy_fall", t_bfall, t_valid - 1);
      chk("8n1_data", data_a, 8'hA5);
      chk("8n1_perr", perr_a, 0);
      chk("8n1_ferr", ferr_a, 0);
      chk("8n1_vcount", v_rise, 1);
      chk("8n1_accepted", valid_a, 0);

      send(1, frame(9'h035, 7, 1, 1'b1, 2'b11, 1), 10, -1, -1);
      chk("7o1_valid", valid_b, 1);
      chk("7o1_data", data_b, 7'h35);
      chk("7o1_perr", perr_b, 0);
      rdy_b = 1'b1;
      tick(1);
      rdy_b = 1'b0;
      chk("7o1_accept", valid_b, 0);
      send(1, frame(9'h035, 7, 1, 1'b0, 2'b11, 1), 10, -1, -1);
      chk("7o1_bad_valid", valid_b, 1);
      chk("7o1_bad_data", data_b, 7'h35);
      chk("7o1_bad_perr", perr_b, 1);
      chk("7o1_bad_ferr", ferr_b, 0);

      send(2, frame(9'h03C, 8, 0, 1'b0, 2'b01, 2), 11, -1, -1);
      chk("8n2_valid", valid_c, 1);
      chk("8n2_data", data_c, 8'h3C);
      chk("8n2_ferr", ferr_c, 1);
      rdy_c = 1'b1;
      tick(1);
      rdy_c = 1'b0;
      send(2, frame(9'h03C, 8, 0, 1'b0, 2'b11, 2), 11, 3 * DIV + 8, -1);
      chk("glitch_valid", valid_c, 1);
      chk("glitch_data", data_c, 8'h3C);
      chk("glitch_ferr", ferr_c, 0);

      b0 = b_rise;
      v0 = v_rise;
      rxd_a = 1'b0;
      tick(3);
      rxd_a = 1'b1;
      tick(30);
      chk("fstart_busy_pulse", b_rise, b0 + 1);
      chk("fstart_busy_low", busy_a, 0);
      chk("fstart_no_valid", v_rise, v0);

      br0 = brk_cnt;
      rxd_a = 1'b0;
      tick(12 * DIV);
      chk("brk_pulse", brk_cnt, br0 + 1);
      chk("brk_no_valid", v_rise, v0);
      chk("brk_busy_low", busy_a, 0);
      chk("brk_one_start", b_rise, b0 + 2);
      rxd_a = 1'b1;
      tick(40);
      chk("brk_idle_busy", b_rise, b0 + 2);
      chk("brk_single", brk_cnt, br0 + 1);

      rdy_a = 1'b0;
      ov0 = ovr_cnt;
      send(0, frame(9'h011, 8, 0, 1'b0, 2'b11, 1), 10, -1, -1);
      chk("ovr_first_valid", valid_a, 1);
      chk("ovr_first_data", data_a, 8'h11);
      send(0, frame(9'h022, 8, 0, 1'b0, 2'b11, 1), 10, -1, -1);
      chk("ovr_held_data", data_a, 8'h11);
      chk("ovr_pulse", ovr_cnt, ov0 + 1);
      chk("ovr_still_valid", valid_a, 1);
      send(0, frame(9'h033, 8, 0, 1'b0, 2'b11, 1), 10, -1, 155);
      chk("acc_load_data", data_a, 8'h33);
      chk("acc_load_valid", valid_a, 1);
      chk("acc_no_ovr", ovr_cnt, ov0 + 1);

      rxd_a = 1'b0;
      tick(DIV);
      rxd_a = 1'b1;
      tick(DIV + 8);
      chk("pre_rst_busy", busy_a, 1);
      nrst = 1'b0;
      #1;
      chk("arst_valid", valid_a, 0);
      chk("arst_data", data_a, 0);
      chk("arst_busy", busy_a, 0);
      chk("arst_flags", {perr_a, ferr_a, ovr_a, brk_a}, 0);
      tick(3);
      nrst = 1'b1;
      b1 = b_rise;
      tick(40);
      chk("post_rst_no_start", b_rise, b1);
      chk("post_rst_busy", busy_a, 0);
      rdy_a = 1'b1;
      v0 = v_rise;
      send(0, frame(9'h05A, 8, 0, 1'b0, 2'b11, 1), 10, -1, -1);
      chk("post_rst_data", data_a, 8'h5A);
      chk("post_rst_vcount", v_rise, v0 + 1);
      chk("post_rst_ferr", ferr_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
